eigen_scheduler: RTL and testbench
==================================

EIGEN_SCHEDULER -- requirements
Module: eigen_scheduler

Interface
REQ-001 SHALL have parameter SIZE_N, default 8, vector length forwarded to the datapath (no internal use beyond documentation).
REQ-002 SHALL have parameter MAX_ITER, default 8, maximum power iterations per eigenvector; legal range 1..255.
REQ-003 SHALL have parameter NUM_EIG, default 4, number of eigenvectors extracted per run; legal range 1..16.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  run request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous abort; effective in any non-IDLE state.
REQ-008 load_vec  out  1  one-cycle pulse: load initial vector for eig_idx into the iteration registers.
REQ-009 mult_start / mult_done  out / in  1 / 1  matrix-vector multiply handshake.
REQ-010 conv_start / conv_done / conv_ok  out / in / in  1 / 1 / 1  convergence-check handshake; conv_ok valid with conv_done.
REQ-011 defl_start / defl_done  out / in  1 / 1  deflation-unit handshake.
REQ-012 eig_idx  out  EW=max(1,clog2(NUM_EIG))  index of the eigenvector in progress.
REQ-013 iter_k  out  KW=clog2(MAX_ITER+1)  completed iterations for current eigenvector.
REQ-014 eig_valid / eig_iters / eig_conv  out / out / out  1 / KW / 1  one-cycle result strobe, iteration count, converged flag.
REQ-015 busy / done / aborted  out  1 each  busy level; done and aborted are one-cycle pulses.

Function
REQ-016 SHALL implement states IDLE, LOAD, MULT, CHECK, DEFL, FIN.
REQ-017 IDLE: start=1 -> LOAD, eig_idx<=0, iter_k<=0; start in any other state ignored.
REQ-018 LOAD: load_vec=1 for exactly one cycle; next cycle -> MULT.
REQ-019 Entry to MULT/CHECK/DEFL SHALL assert mult_start/conv_start/defl_start respectively for exactly the entry cycle.
REQ-020 A *_done input SHALL be ignored in the cycle its *_start is high and in any state other than its owning state.
REQ-021 MULT: mult_done=1 -> CHECK, iter_k<=iter_k+1 (saturating at MAX_ITER).
REQ-022 CHECK: conv_done=1 and (conv_ok=1 or iter_k==MAX_ITER) -> eig_valid=1 next cycle with eig_iters=iter_k, eig_conv=conv_ok; then DEFL if eig_idx<NUM_EIG-1, else FIN.
REQ-023 CHECK: conv_done=1, conv_ok=0, iter_k<MAX_ITER -> MULT (new mult_start).
REQ-024 DEFL: defl_done=1 -> LOAD, eig_idx<=eig_idx+1, iter_k<=0.
REQ-025 FIN: done=1 for one cycle -> IDLE; eig_idx and iter_k hold final values until next start.
REQ-026 busy SHALL be 1 in every state except IDLE, combinationally from state.
REQ-027 abort=1 in non-IDLE -> IDLE next cycle, aborted=1 for one cycle, all *_start, load_vec, eig_valid, done forced 0 that cycle; abort wins over any simultaneous *_done.
REQ-028 abort in IDLE SHALL have no effect; abort and start together in IDLE -> start honoured.
REQ-029 No *_start pulse SHALL be issued while waiting for a *_done; handshakes are strictly one outstanding.
REQ-030 Minimum per-iteration latency: mult_start to next mult_start = 4 cycles when each done returns one cycle after its start.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE and all outputs to 0, including eig_idx, iter_k, eig_iters, eig_conv.
REQ-032 Reset mid-run SHALL discard the run; no done, aborted or eig_valid pulse on release.

Verification
REQ-033 NUM_EIG=2, MAX_ITER=8, conv_ok=1 on 3rd check -> eig_valid with eig_iters=3, eig_conv=1, eig_idx 0; then defl_start, eig_idx=1; second converges at 3 -> done pulse, no defl_start.
REQ-034 conv_ok always 0, MAX_ITER=4, NUM_EIG=1 -> exactly 4 mult_start pulses, eig_iters=4, eig_conv=0, done.
REQ-035 mult_done held high continuously -> ignored in mult_start cycle; exactly one CHECK entry per mult_start.
REQ-036 abort during DEFL with simultaneous defl_done -> aborted pulse, IDLE, no load_vec.
REQ-037 rst asserted mid-MULT, released, start -> eig_idx=0, iter_k=0, load_vec pulse, clean run.
REQ-038 start pulsed while busy -> ignored; run count and eig_valid count unchanged.

Source files
------------

// File: rtl/eigen_scheduler.sv
// Sequencer for the eigen-decomposition datapath: power iterations per
// eigenvector via mult/conv/defl handshakes, one outstanding request at a time.
module eigen_scheduler #(
  parameter int SIZE_N   = 8,
  parameter int MAX_ITER = 8,
  parameter int NUM_EIG  = 4,
  localparam int EW = (NUM_EIG > 1) ? $clog2(NUM_EIG) : 1,
  localparam int KW = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          load_vec,
  output logic          mult_start,
  input  logic          mult_done,
  output logic          conv_start,
  input  logic          conv_done,
  input  logic          conv_ok,
  output logic          defl_start,
  input  logic          defl_done,
  output logic [EW-1:0] eig_idx,
  output logic [KW-1:0] iter_k,
  output logic          eig_valid,
  output logic [KW-1:0] eig_iters,
  output logic          eig_conv,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MULT  = 3'd2,
    CHECK = 3'd3,
    DEFL  = 3'd4,
    FIN   = 3'd5
  } state_t;

  // SIZE_N only describes the datapath; it has no effect on sequencing.
  if (SIZE_N < 1) begin : g_size_guard
  end

  state_t          state_r, state_n;
  logic [EW-1:0]   eig_idx_n;
  logic [KW-1:0]   iter_k_n;
  logic [KW-1:0]   eig_iters_n;
  logic            eig_conv_n;
  logic            eig_valid_n;
  logic            aborted_n;

  localparam logic [EW-1:0] LAST_EIG = EW'(NUM_EIG - 1);
  localparam logic [KW-1:0] ITER_MAX = KW'(MAX_ITER);

  // Next-state, counter and result-capture logic.
  always_comb begin
    state_n     = state_r;
    eig_idx_n   = eig_idx;
    iter_k_n    = iter_k;
    eig_iters_n = eig_iters;
    eig_conv_n  = eig_conv;
    eig_valid_n = 1'b0;
    aborted_n   = 1'b0;
    if ((state_r != IDLE) && abort) begin
      state_n   = IDLE;
      aborted_n = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_n   = LOAD;
            eig_idx_n = '0;
            iter_k_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end
        LOAD: state_n = MULT;
        // A done coinciding with its own start strobe is stale and dropped.
        MULT: begin
          if (mult_done && !mult_start) begin
            state_n  = CHECK;
            iter_k_n = (iter_k < ITER_MAX) ? iter_k + KW'(1) : ITER_MAX;
          end else begin
            state_n = MULT;
          end
        end
        CHECK: begin
          if (conv_done && !conv_start) begin
            if (conv_ok || (iter_k == ITER_MAX)) begin
              eig_valid_n = 1'b1;
              eig_iters_n = iter_k;
              eig_conv_n  = conv_ok;
              state_n     = (eig_idx == LAST_EIG) ? FIN : DEFL;
            end else begin
              state_n = MULT;
            end
          end else begin
            state_n = CHECK;
          end
        end
        DEFL: begin
          if (defl_done && !defl_start) begin
            state_n   = LOAD;
            eig_idx_n = eig_idx + EW'(1);
            iter_k_n  = '0;
          end else begin
            state_n = DEFL;
          end
        end
        FIN:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State register and registered strobes, raised on the cycle a state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      eig_idx    <= '0;
      iter_k     <= '0;
      eig_iters  <= '0;
      eig_conv   <= 1'b0;
      eig_valid  <= 1'b0;
      aborted    <= 1'b0;
      load_vec   <= 1'b0;
      mult_start <= 1'b0;
      conv_start <= 1'b0;
      defl_start <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_n;
      eig_idx    <= eig_idx_n;
      iter_k     <= iter_k_n;
      eig_iters  <= eig_iters_n;
      eig_conv   <= eig_conv_n;
      eig_valid  <= eig_valid_n;
      aborted    <= aborted_n;
      load_vec   <= (state_n == LOAD)  && (state_r != LOAD);
      mult_start <= (state_n == MULT)  && (state_r != MULT);
      conv_start <= (state_n == CHECK) && (state_r != CHECK);
      defl_start <= (state_n == DEFL)  && (state_r != DEFL);
      done       <= (state_n == FIN)   && (state_r != FIN);
    end
  end

  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_eigen_scheduler.sv
// Randomized bench for eigen_scheduler: a handshake responder plus a
// per-eigenvector reference model of iteration counts and strobes.
module tb_eigen_scheduler;

  localparam int SIZE_N   = 8;
  localparam int MAX_ITER = 4;
  localparam int NUM_EIG  = 3;
  localparam int EW = (NUM_EIG > 1) ? $clog2(NUM_EIG) : 1;
  localparam int KW = $clog2(MAX_ITER + 1);

  logic          clk, rst, start, abort;
  logic          load_vec, mult_start, mult_done;
  logic          conv_start, conv_done, conv_ok;
  logic          defl_start, defl_done;
  logic [EW-1:0] eig_idx;
  logic [KW-1:0] iter_k, eig_iters;
  logic          eig_valid, eig_conv, busy, done, aborted;

  int checks = 0;
  int errors = 0;
  // check number at which conv_ok is returned for each eigenvector
  int conv_at [NUM_EIG];

  eigen_scheduler #(.SIZE_N(SIZE_N), .MAX_ITER(MAX_ITER), .NUM_EIG(NUM_EIG)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_vec(load_vec), .mult_start(mult_start), .mult_done(mult_done),
    .conv_start(conv_start), .conv_done(conv_done), .conv_ok(conv_ok),
    .defl_start(defl_start), .defl_done(defl_done),
    .eig_idx(eig_idx), .iter_k(iter_k), .eig_valid(eig_valid),
    .eig_iters(eig_iters), .eig_conv(eig_conv),
    .busy(busy), .done(done), .aborted(aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs;
    start = 1'b0; abort = 1'b0;
    mult_done = 1'b0; conv_done = 1'b0; conv_ok = 1'b0; defl_done = 1'b0;
  endtask

  function automatic int exp_iters(input int c);
    return (c < MAX_ITER) ? c : MAX_ITER;
  endfunction

  // One full run, acting as the datapath and checking against the model.
  task automatic run(input int max_delay, input bit hold_mult, input bit spurious,
                     input bit abort_defl, input bit rst_mid, input bit abort_with_start);
    int e = -1, loads = 0, valids = 0, defls = 0;
    int mt = 0, ct = 0, dt = 0, chk = 0, mstarts = 0, last_ms = 0, cyc = 0;
    bit ok_pend = 1'b0, fin = 1'b0;
    start = 1'b1; abort = abort_with_start;
    tick;
    start = 1'b0; abort = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_no_abort", 32'(aborted), 32'd0);
    while (cyc < 3000) begin
      if (load_vec) begin
        loads++; e++; chk = 0; mstarts = 0;
        check("load_idx", 32'(eig_idx), 32'(e));
        check("load_iter", 32'(iter_k), 32'd0);
      end
      if (eig_valid) begin
        valids++;
        check("valid_idx", 32'(eig_idx), 32'(e));
        check("valid_iters", 32'(eig_iters), 32'(exp_iters(conv_at[e])));
        check("valid_conv", 32'(eig_conv), 32'(conv_at[e] <= MAX_ITER));
        check("mult_count", 32'(mstarts), 32'(exp_iters(conv_at[e])));
      end
      if (done) begin
        fin = 1'b1;
        break;
      end
      mult_done = hold_mult; conv_done = 1'b0; conv_ok = 1'b0; defl_done = 1'b0;
      start = spurious && ($urandom_range(0, 3) == 0);
      if (mt > 0) begin mt--; if (mt == 0) mult_done = 1'b1; end
      if (ct > 0) begin ct--; if (ct == 0) begin conv_done = 1'b1; conv_ok = ok_pend; end end
      if (dt > 0) begin
        dt--;
        if (dt == 0) begin
          defl_done = 1'b1;
          if (abort_defl) begin
            abort = 1'b1;
            tick;
            check("abort_pulse", 32'(aborted), 32'd1);
            check("abort_idle", 32'(busy), 32'd0);
            check("abort_no_load", 32'(load_vec), 32'd0);
            clear_inputs();
            tick;
            check("abort_one_cycle", 32'(aborted), 32'd0);
            check("abort_no_load2", 32'(load_vec), 32'd0);
            return;
          end
        end
      end
      if (mult_start) begin
        check("mult_outstanding", 32'(mt), 32'd0);
        mstarts++;
        if (max_delay == 1 && mstarts > 1) check("iter_latency", 32'(cyc - last_ms), 32'd4);
        last_ms = cyc;
        mt = (max_delay == 1) ? 1 : $urandom_range(1, max_delay);
        if (rst_mid && e == 1) begin
          rst = 1'b1;
          #1;
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_idx", 32'(eig_idx), 32'd0);
          check("rst_iter", 32'(iter_k), 32'd0);
          check("rst_mult_start", 32'(mult_start), 32'd0);
          check("rst_eig_iters", 32'(eig_iters), 32'd0);
          check("rst_eig_conv", 32'(eig_conv), 32'd0);
          clear_inputs();
          tick; tick;
          rst = 1'b0;
          for (int i = 0; i < 4; i++) begin
            tick;
            check("rst_no_pulse", 32'({done, aborted, eig_valid, busy}), 32'd0);
          end
          return;
        end
      end
      if (conv_start) begin
        chk++;
        check("conv_iter", 32'(iter_k), 32'(chk));
        check("conv_outstanding", 32'(ct), 32'd0);
        ct = (max_delay == 1) ? 1 : $urandom_range(1, max_delay);
        ok_pend = (chk == conv_at[e]);
      end
      if (defl_start) begin
        defls++;
        dt = (max_delay == 1) ? 1 : $urandom_range(1, max_delay);
      end
      tick;
      cyc++;
    end
    clear_inputs();
    check("run_timeout", 32'(fin), 32'd1);
    check("done_idx", 32'(eig_idx), 32'(NUM_EIG - 1));
    check("load_count", 32'(loads), 32'(NUM_EIG));
    check("valid_count", 32'(valids), 32'(NUM_EIG));
    check("defl_count", 32'(defls), 32'(NUM_EIG - 1));
    check("fin_busy", 32'(busy), 32'd1);
    tick;
    check("idle_busy", 32'(busy), 32'd0);
    check("done_width", 32'(done), 32'd0);
    check("hold_idx", 32'(eig_idx), 32'(NUM_EIG - 1));
    check("hold_iter", 32'(iter_k), 32'(exp_iters(conv_at[NUM_EIG - 1])));
    tick;
    check("stay_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick; tick;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_strobes", 32'({load_vec, mult_start, conv_start, defl_start, eig_valid, done, aborted}), 32'd0);
    check("reset_idx", 32'(eig_idx), 32'd0);
    check("reset_iter", 32'(iter_k), 32'd0);
    check("reset_results", 32'({eig_iters, eig_conv}), 32'd0);
    rst = 1'b0;
    tick;

    abort = 1'b1;
    tick; tick;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_pulse", 32'(aborted), 32'd0);
    abort = 1'b0;
    tick;

    // converge on the third check, unit handshake latency
    for (int i = 0; i < NUM_EIG; i++) conv_at[i] = 3;
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // never converge: iteration cap
    for (int i = 0; i < NUM_EIG; i++) conv_at[i] = MAX_ITER + 5;
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // mult_done held high throughout
    conv_at[0] = 2; conv_at[1] = 5; conv_at[2] = 1;
    run(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // random delays, random convergence, spurious start while busy
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM_EIG; i++) conv_at[i] = $urandom_range(1, MAX_ITER + 2);
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // abort with simultaneous defl_done
    for (int i = 0; i < NUM_EIG; i++) conv_at[i] = 2;
    run(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset mid-MULT of the second eigenvector, then a clean run
    run(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NUM_EIG; i++) conv_at[i] = $urandom_range(1, MAX_ITER);
    run(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // abort and start together in IDLE: start is honoured
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
